// File: rtl/en_strobe_gen_pkg.sv
// Shared types and default widths for the en strobe generator.
package en_strobe_pkg;

    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned BURST_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/en_strobe_gen_period_down_cnt.sv
// Loadable down-counter that sets the spacing between en strobes.
module period_down_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec)
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/en_strobe_gen.sv
// Periodic single-cycle en strobe generator with continuous or burst operation.
// Optional build macro: EN_STROBE_GEN_AUTORELOAD_EN (burst restarts instead of ending).
module en_strobe_gen
    import en_strobe_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   div,
    input  logic [BURST_W-1:0] burst_len,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   div_q;
    logic [BURST_W-1:0] burst_q;
    logic [CNT_W-1:0]   div_eff;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_count;
    logic               latch_cfg, pc_clr, pc_inc, done_nxt, burst_last;

    assign div_eff = (div == '0) ? CNT_W'(1) : div;

    period_down_cnt #(.CNT_W(CNT_W)) u_period (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    // Outputs are decoded from registered state only, never from inputs.
    assign en   = (state == RUN) && cnt_zero;
    assign busy = (state == RUN);

    assign burst_last = en && (burst_q != '0) && ((pulse_cnt + BURST_W'(1)) == burst_q);

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = div_q - CNT_W'(1);
        cnt_dec      = 1'b0;
        latch_cfg    = 1'b0;
        pc_clr       = 1'b0;
        pc_inc       = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt    = RUN;
                    latch_cfg    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = div_eff - CNT_W'(1);
                    pc_clr       = 1'b1;
                end
            end
            RUN: begin
                pc_inc = en;
                if (en)
                    cnt_load = 1'b1;
                else
                    cnt_dec = 1'b1;
                // Stop beats completion: the last pulse still counts but no done.
                if (stop) begin
                    state_nxt = IDLE;
                end else if (burst_last) begin
                    done_nxt = 1'b1;
`ifdef EN_STROBE_GEN_AUTORELOAD_EN
                    pc_clr = 1'b1;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_q     <= '0;
            burst_q   <= '0;
            pulse_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (latch_cfg) begin
                div_q   <= div_eff;
                burst_q <= burst_len;
            end
            if (pc_clr)
                pulse_cnt <= '0;
            else if (pc_inc)
                pulse_cnt <= pulse_cnt + BURST_W'(1);
        end
    end

endmodule

// File: tb/tb_en_strobe_gen.sv
// Directed self-checking bench for en_strobe_gen; cycle n = n-th cycle after the start-sampling edge.
module tb_en_strobe_gen;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [7:0] div, burst_len;
    logic       en, busy, done;
    logic [7:0] pulse_cnt;

    int vectors    = 0;
    int miscompares = 0;

    en_strobe_gen #(.CNT_W(8), .BURST_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .burst_len (burst_len),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rst = 1'b1; start = 1'b1; stop = 1'b0; div = 8'd2; burst_len = 8'd0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== 11'd0) begin
                miscompares++;
                $display("FAIL reset c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, 11'd0);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_rise got %b want 1", busy);
        end
        start = 1'b0;
        go_idle();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stop_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_burst();
        logic [10:0] obs, exp;
        logic        e_en, e_busy, e_done;
        logic [7:0]  e_pc;
        div = 8'd4; burst_len = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        e_pc = 8'd0;
        for (int c = 1; c <= 16; c++) begin
            e_en   = (c == 4) || (c == 8) || (c == 12);
            e_busy = (c < 13);
            e_done = (c == 13);
            exp = {e_en, e_busy, e_done, e_pc};
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL burst c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, exp);
            end
            if (e_en) e_pc = e_pc + 8'd1;
            tick();
        end
    endtask

    task automatic test_continuous();
        logic [10:0] obs, exp;
        div = 8'd0; burst_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            exp = {1'b1, 1'b1, 1'b0, 8'((c - 1) % 256)};
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL cont c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, exp);
            end
            if (c == 300) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        for (int c = 301; c <= 305; c++) begin
            exp = {1'b0, 1'b0, 1'b0, 8'd44};
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL cont_stop c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_stop_with_en();
        logic [10:0] obs, exp;
        logic [7:0]  e_pc;
        div = 8'd5; burst_len = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        e_pc = 8'd0;
        for (int c = 1; c <= 10; c++) begin
            exp = {(c == 5) || (c == 10), 1'b1, 1'b0, e_pc};
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stop_en c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, exp);
            end
            if (c == 5) e_pc = 8'd1;
            if (c == 10) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        for (int c = 11; c <= 20; c++) begin
            exp = {1'b0, 1'b0, 1'b0, 8'd2};
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stop_en_after c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_start_stop();
        logic [1:0] obs2;
        logic       e_en;
        div = 8'd3; burst_len = 8'd0; start = 1'b1; stop = 1'b1;
        tick();
        obs2 = {en, busy};
        vectors++;
        if (obs2 !== 2'b00) begin
            miscompares++;
            $display("FAIL start_stop_idle {en,busy} got %b want 00", obs2);
        end
        stop = 1'b0;
        tick();
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) begin
                div = 8'd7;
                start = 1'b1;
            end
            e_en = (c % 3 == 0);
            vectors++;
            if ({en, busy} !== {e_en, 1'b1}) begin
                miscompares++;
                $display("FAIL start_in_run c%0d {en,busy} got %b%b want %b1", c, en, busy, e_en);
            end
            tick();
        end
        start = 1'b0;
        go_idle();
    endtask

`ifdef EN_STROBE_GEN_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [10:0] obs, exp;
        div = 8'd2; burst_len = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            exp = {(c % 2 == 0), 1'b1, (c >= 5) && ((c - 1) % 4 == 0), 8'(((c - 1) / 2) % 2)};
            obs = {en, busy, done, pulse_cnt};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL autoreload c%0d {en,busy,done,pulse_cnt} got %h want %h", c, obs, exp);
            end
            if (c == 21) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        obs = {en, busy, done, pulse_cnt};
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL autoreload_rst {en,busy,done,pulse_cnt} got %h want %h", obs, 11'd0);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; div = '0; burst_len = '0;
        test_reset();
`ifdef EN_STROBE_GEN_AUTORELOAD_EN
        test_autoreload();
`else
        test_burst();
`endif
        test_continuous();
        test_stop_with_en();
        test_start_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
